// File: rtl/register_file.sv
// RV32I integer register file: 32 x DWIDTH storage, two combinational read
// ports, one clocked write-back port. x0 always reads zero; x2 (sp) resets
// to SP_RESET and every other register resets to zero.
module register_file #(
  parameter int unsigned           DWIDTH   = 32,
  parameter logic [DWIDTH-1:0]     SP_RESET = 32'h0110_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  input  logic [DWIDTH-1:0] datawb_i,
  input  logic              regwren_i,
  output logic [DWIDTH-1:0] rs1data_o,
  output logic [DWIDTH-1:0] rs2data_o
);

  logic [DWIDTH-1:0] regs [32];

  // Reset image has priority; otherwise commit enabled write-back, dropping x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i[4:0]] <= (i == 32'd2) ? SP_RESET : '0;
      end
    end else if (regwren_i && (rd_i != 5'd0)) begin
      regs[rd_i] <= datawb_i;
    end
  end

  // Combinational reads with no write bypass; index 0 is forced to zero
  // so x0 reads zero even before the first reset.
  always_comb begin
    rs1data_o = '0;
    rs2data_o = '0;
    if (rs1_i != 5'd0) rs1data_o = regs[rs1_i];
    if (rs2_i != 5'd0) rs2data_o = regs[rs2_i];
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed plan with literal expectations, then
// randomized traffic against an array model of the architectural registers.
module tb_register_file;

  localparam logic [31:0] SP = 32'h0110_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [31:0] datawb_i;
  logic        regwren_i;
  logic [31:0] rs1data_o, rs2data_o;

  register_file #(.DWIDTH(32), .SP_RESET(SP)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_i      (rd_i),
    .datawb_i  (datawb_i),
    .regwren_i (regwren_i),
    .rs1data_o (rs1data_o),
    .rs2data_o (rs2data_o)
  );

  always #5 clk = ~clk;

  // Architectural model: what each register must hold after every edge.
  logic [31:0] model [32];
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= (i == 2) ? SP : 32'd0;
      model_valid <= 1'b1;
    end else if (regwren_i && rd_i != 5'd0) begin
      model[rd_i] <= datawb_i;
    end
  end

  // Hand-computed expectations pinned for one cycle by the directed sequence.
  logic        pin_en = 1'b0;
  logic [31:0] pin1, pin2;
  string       pin_name = "";

  int vectors = 0;
  int miscompares = 0;

  // Single compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e1, e2;
    if (model_valid) begin
      e1 = (rs1_i == 5'd0) ? 32'd0 : model[rs1_i];
      e2 = (rs2_i == 5'd0) ? 32'd0 : model[rs2_i];
      vectors++;
      if (rs1data_o !== e1) begin
        miscompares++;
        $display("FAIL model_rs1 t=%0t rs1=%0d got=%h exp=%h", $time, rs1_i, rs1data_o, e1);
      end
      vectors++;
      if (rs2data_o !== e2) begin
        miscompares++;
        $display("FAIL model_rs2 t=%0t rs2=%0d got=%h exp=%h", $time, rs2_i, rs2data_o, e2);
      end
    end else if (rs1_i == 5'd0 || rs2_i == 5'd0) begin
      // x0 must read zero even before any reset.
      vectors++;
      if ((rs1_i == 5'd0 && rs1data_o !== 32'd0) || (rs2_i == 5'd0 && rs2data_o !== 32'd0)) begin
        miscompares++;
        $display("FAIL x0_prereset got=%h/%h exp=00000000", rs1data_o, rs2data_o);
      end
    end
    if (pin_en) begin
      vectors++;
      if (rs1data_o !== pin1 || rs2data_o !== pin2) begin
        miscompares++;
        $display("FAIL %s got=%h/%h exp=%h/%h", pin_name, rs1data_o, rs2data_o, pin1, pin2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin(input string name, input logic [31:0] e1, input logic [31:0] e2);
    pin_name = name;
    pin1 = e1;
    pin2 = e2;
    pin_en = 1'b1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    rd_i = rd; datawb_i = d; regwren_i = 1'b1;
    step();
    regwren_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0;
    datawb_i = 32'd0; regwren_i = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;

    // Reset image.
    rs1_i = 0; rs2_i = 2; pin("reset_x0_sp", 32'h0, SP); step();
    rs1_i = 5; rs2_i = 31; pin("reset_x5_x31", 32'h0, 32'h0); step();

    // x0 discards writes.
    rd_i = 0; datawb_i = 32'hDEADBEEF; regwren_i = 1'b1;
    step(); step();
    regwren_i = 1'b0;
    rs1_i = 0; rs2_i = 0; pin("x0_hardwired", 32'h0, 32'h0); step();

    // Basic writes and dual read, then overwrite.
    wr(1, 32'h12345678);
    wr(31, 32'hABCDEF00);
    rs1_i = 1; rs2_i = 31; pin("dual_read", 32'h12345678, 32'hABCDEF00); step();
    wr(1, 32'h87654321);
    pin("overwrite_x1", 32'h87654321, 32'hABCDEF00); step();

    // Write enable gating.
    rd_i = 5; datawb_i = 32'hBADDA7A1; regwren_i = 1'b0;
    step(); step(); step();
    rs1_i = 5; rs2_i = 2; pin("wren_gating", 32'h0, SP); step();

    // Back-to-back writes.
    wr(10, 32'h11111111);
    wr(20, 32'h22222222);
    rs1_i = 10; rs2_i = 20; pin("back_to_back", 32'h11111111, 32'h22222222); step();
    rs1_i = 2; rs2_i = 0; pin("sp_intact", SP, 32'h0); step();

    // Same-cycle read/write of x7: old value before the edge, new after.
    rs1_i = 7; rs2_i = 7;
    rd_i = 7; datawb_i = 32'h77777777; regwren_i = 1'b1;
    pin("rdw_before_edge", 32'h0, 32'h0);
    step();
    regwren_i = 1'b0;
    pin("rdw_after_edge", 32'h77777777, 32'h77777777); step();

    // x2 is writable after reset.
    wr(2, 32'h00000FF0);
    rs1_i = 2; rs2_i = 7; pin("sp_overwrite", 32'h00000FF0, 32'h77777777); step();

    // Reset beats a simultaneous write and wipes prior writes.
    rst = 1'b1; rd_i = 3; datawb_i = 32'hCAFEF00D; regwren_i = 1'b1;
    rs1_i = 3; rs2_i = 2;
    step();
    rst = 1'b0; regwren_i = 1'b0;
    pin("reset_priority", 32'h0, SP); step();
    rs1_i = 1; rs2_i = 31; pin("reset_wipes", 32'h0, 32'h0); step();

    // Randomized traffic, occasional mid-run resets; reads often hit the
    // register being written to exercise read-during-write.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      regwren_i = ($urandom_range(0, 3) != 0);
      rd_i      = 5'($urandom_range(0, 31));
      datawb_i  = $urandom;
      rs1_i     = ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom_range(0, 31));
      rs2_i     = ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom_range(0, 31));
      step();
    end
    rst = 1'b0; regwren_i = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
